// File: rtl/seven_segment_mux_ctrl.sv
// -----------------------------------------------------------------------------
// seven_segment_mux_ctrl
//   Time-multiplexed driver for a common-anode seven-segment display.
//   One digit is driven at a time for a dwell of COUNT_TO+1 clocks. Inputs are
//   snapshotted once per frame so a whole frame always shows one coherent value.
//   Each dwell starts with one dark clock to hide ghosting. Brightness comes from
//   a free-running 4-bit PWM compare. Leading zeros can be blanked.
//
// Ports
//   clk_in          single clock, rising edge
//   rst_n_in        synchronous active-low reset
//   val_in          hex nibble per digit, digit i = val_in[4i+3:4i]
//   dp_in           decimal-point request per digit (active-high)
//   en_in           per-digit enable; 0 keeps the digit dark
//   lz_en_in        leading-zero suppression enable
//   bright_in       brightness 0 (dimmest) .. 15 (full)
//   cat_out         segment cathodes {g,f,e,d,c,b,a}, active-low, registered
//   dp_out          decimal-point cathode, active-low, registered
//   an_out          digit anodes, active-low, at most one low, registered
//   frame_done_out  one-cycle pulse after the last dwell of a frame
// -----------------------------------------------------------------------------
module seven_segment_mux_ctrl #(
    parameter int NUM_DIGITS = 8,
    parameter int COUNT_TO   = 100_000
) (
    input  logic                    clk_in,
    input  logic                    rst_n_in,
    input  logic [4*NUM_DIGITS-1:0] val_in,
    input  logic [NUM_DIGITS-1:0]   dp_in,
    input  logic [NUM_DIGITS-1:0]   en_in,
    input  logic                    lz_en_in,
    input  logic [3:0]              bright_in,
    output logic [6:0]              cat_out,
    output logic                    dp_out,
    output logic [NUM_DIGITS-1:0]   an_out,
    output logic                    frame_done_out
);

    localparam int CNT_W = (COUNT_TO > 0) ? $clog2(COUNT_TO + 1) : 1;
    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(COUNT_TO);
    localparam logic [IDX_W-1:0] IDX_MAX = IDX_W'(NUM_DIGITS - 1);

    // scan state
    logic [CNT_W-1:0]        r_cnt;
    logic [IDX_W-1:0]        r_idx;
    logic [3:0]              r_pwm;

    // per-frame snapshot of the inputs
    logic [4*NUM_DIGITS-1:0] r_val;
    logic [NUM_DIGITS-1:0]   r_dp;
    logic [NUM_DIGITS-1:0]   r_en;
    logic                    r_lz;
    logic [3:0]              r_bright;

    // registered outputs
    logic [6:0]              r_cat;
    logic                    r_dp_out;
    logic [NUM_DIGITS-1:0]   r_an;
    logic                    r_frame_done;

    logic                    w_cnt_wrap;
    logic                    w_last_digit;
    logic                    w_frame_start;
    logic [NUM_DIGITS-1:0]   w_blank;
    logic                    w_run_zero;
    logic [3:0]              w_nib;
    logic                    w_dig_en;
    logic                    w_dig_dp;
    logic                    w_dig_blank;
    logic                    w_lit;
    logic [6:0]              w_seg;
    logic [NUM_DIGITS-1:0]   w_an_nxt;

    assign w_cnt_wrap    = (r_cnt == CNT_MAX);
    assign w_last_digit  = (r_idx == IDX_MAX);
    assign w_frame_start = (r_cnt == '0) && (r_idx == '0);

    // Leading-zero blanking: walk down from the top digit while everything seen
    // so far is a zero nibble without a decimal point. Digit 0 always shows.
    always_comb begin
        w_blank    = '0;
        w_run_zero = 1'b1;
        for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
            w_run_zero = w_run_zero && (r_val[4*i +: 4] == 4'h0) && !r_dp[i];
            w_blank[i] = r_lz && w_run_zero;
        end
    end

    // Select the active digit's attributes; compare-based mux keeps the index
    // width independent of NUM_DIGITS being a power of two.
    always_comb begin
        w_nib       = 4'h0;
        w_dig_en    = 1'b0;
        w_dig_dp    = 1'b0;
        w_dig_blank = 1'b0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (r_idx == IDX_W'(i)) begin
                w_nib       = r_val[4*i +: 4];
                w_dig_en    = r_en[i];
                w_dig_dp    = r_dp[i];
                w_dig_blank = w_blank[i];
            end
        end
    end

    // cnt==0 is the dark guard slot between digits
    assign w_lit = (r_cnt != '0) && w_dig_en && !w_dig_blank && (r_pwm <= r_bright);

    always_comb begin
        w_an_nxt = '1;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (w_lit && (r_idx == IDX_W'(i))) begin
                w_an_nxt[i] = 1'b0;
            end
        end
    end

    // active-high segments {g,f,e,d,c,b,a}
    always_comb begin
        w_seg = 7'h00;
        case (w_nib)
            4'h0: w_seg = 7'h3F;
            4'h1: w_seg = 7'h06;
            4'h2: w_seg = 7'h5B;
            4'h3: w_seg = 7'h4F;
            4'h4: w_seg = 7'h66;
            4'h5: w_seg = 7'h6D;
            4'h6: w_seg = 7'h7D;
            4'h7: w_seg = 7'h07;
            4'h8: w_seg = 7'h7F;
            4'h9: w_seg = 7'h6F;
            4'hA: w_seg = 7'h77;
            4'hB: w_seg = 7'h7C;
            4'hC: w_seg = 7'h39;
            4'hD: w_seg = 7'h5E;
            4'hE: w_seg = 7'h79;
            4'hF: w_seg = 7'h71;
            default: w_seg = 7'h00;
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (!rst_n_in) begin
            r_cnt        <= '0;
            r_idx        <= '0;
            r_pwm        <= 4'h0;
            r_val        <= '0;
            r_dp         <= '0;
            r_en         <= '0;
            r_lz         <= 1'b0;
            r_bright     <= 4'h0;
            r_cat        <= 7'h7F;
            r_dp_out     <= 1'b1;
            r_an         <= '1;
            r_frame_done <= 1'b0;
        end else begin
            r_pwm <= r_pwm + 4'd1;

            if (w_cnt_wrap) begin
                r_cnt <= '0;
                r_idx <= w_last_digit ? '0 : r_idx + 1'b1;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end

            // Frame start is always a dark slot, so the new snapshot is first
            // displayed on the following cycle and never mid-frame.
            if (w_frame_start) begin
                r_val    <= val_in;
                r_dp     <= dp_in;
                r_en     <= en_in;
                r_lz     <= lz_en_in;
                r_bright <= bright_in;
            end

            r_frame_done <= w_cnt_wrap && w_last_digit;
            r_an         <= w_an_nxt;
            r_cat        <= w_lit ? ~w_seg : 7'h7F;
            r_dp_out     <= w_lit ? ~w_dig_dp : 1'b1;
        end
    end

    assign cat_out        = r_cat;
    assign dp_out         = r_dp_out;
    assign an_out         = r_an;
    assign frame_done_out = r_frame_done;

endmodule

// File: tb/tb_seven_segment_mux_ctrl.sv
// -----------------------------------------------------------------------------
// tb_seven_segment_mux_ctrl
//   Self-checking bench for seven_segment_mux_ctrl (NUM_DIGITS=4, COUNT_TO=3).
//   A reference model derives, from the number of clocks elapsed since reset,
//   which digit/slot/PWM phase is active and what the display must show; each
//   expected output word is queued and a monitor compares it on the falling
//   edge. Directed phases (scan, tear-free update, leading zeros, brightness and
//   enable mask, mid-frame reset) are followed by randomized traffic.
// -----------------------------------------------------------------------------
module tb_seven_segment_mux_ctrl;

    localparam int N     = 4;
    localparam int C     = 3;
    localparam int DWELL = C + 1;
    localparam int FRAME = DWELL * N;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [4*N-1:0]  val;
    logic [N-1:0]    dp;
    logic [N-1:0]    en;
    logic            lz;
    logic [3:0]      bright;
    logic [6:0]      cat_out;
    logic            dp_out;
    logic [N-1:0]    an_out;
    logic            frame_done;

    seven_segment_mux_ctrl #(.NUM_DIGITS(N), .COUNT_TO(C)) dut (
        .clk_in         (clk),
        .rst_n_in       (rst_n),
        .val_in         (val),
        .dp_in          (dp),
        .en_in          (en),
        .lz_en_in       (lz),
        .bright_in      (bright),
        .cat_out        (cat_out),
        .dp_out         (dp_out),
        .an_out         (an_out),
        .frame_done_out (frame_done)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [N-1:0] an;
        logic [6:0]   cat;
        logic         dp;
        logic         fd;
    } exp_t;

    exp_t q[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    bit   end_chk = 1'b0;

    // ---------------- reference model ----------------
    int             m_s = 0;   // clocks since reset release (index of next edge)
    logic [4*N-1:0] sh_val = '0;
    logic [N-1:0]   sh_dp = '0, sh_en = '0;
    logic           sh_lz = 1'b0;
    logic [3:0]     sh_bright = 4'h0;

    function automatic logic [6:0] seg7(input logic [3:0] n);
        logic [6:0] t [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                               7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
        return t[n];
    endfunction

    // blanked iff it sits above the most significant "meaningful" digit
    function automatic bit lz_blank(input int i, input logic [4*N-1:0] v,
                                    input logic [N-1:0] d, input logic l);
        int msd = 0;
        for (int j = 0; j < N; j++)
            if (v[4*j +: 4] != 4'h0 || d[j]) msd = j;
        return l && (i > msd);
    endfunction

    always @(posedge clk) begin
        exp_t         e;
        int           cnt, idx, pwm;
        logic [N-1:0] one;
        e   = '{an: '1, cat: 7'h7F, dp: 1'b1, fd: 1'b0};
        one = 1;
        if (!rst_n) begin
            m_s = 0;
        end else begin
            cnt  = m_s % DWELL;
            idx  = (m_s / DWELL) % N;
            pwm  = m_s % 16;
            e.fd = ((m_s % FRAME) == FRAME - 1);
            if (cnt != 0 && sh_en[idx] && !lz_blank(idx, sh_val, sh_dp, sh_lz) && pwm <= int'(sh_bright)) begin
                e.an  = ~(one << idx);
                e.cat = ~seg7(sh_val[4*idx +: 4]);
                e.dp  = ~sh_dp[idx];
            end
            if ((m_s % FRAME) == 0) begin
                sh_val = val; sh_dp = dp; sh_en = en; sh_lz = lz; sh_bright = bright;
            end
            m_s++;
        end
        q.push_back(e);
    end

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        exp_t e, got;
        if (q.size() > 0) begin
            e   = q.pop_front();
            got = {an_out, cat_out, dp_out, frame_done};
            n_tests++;
            if (got !== e) begin
                n_fail++;
                $display("FAIL outputs @%0t: got an=%b cat=%h dp=%b fd=%b, required an=%b cat=%h dp=%b fd=%b",
                         $time, got.an, got.cat, got.dp, got.fd, e.an, e.cat, e.dp, e.fd);
            end
            n_tests++;
            if ($countones(~an_out) > 1) begin
                n_fail++;
                $display("FAIL anode_onehot @%0t: got an=%b, required at most one low", $time, an_out);
            end
        end
        if (end_chk) begin
            n_tests++;
            if (q.size() != 0) begin
                n_fail++;
                $display("FAIL queue_drain: got %0d pending, required 0", q.size());
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic drive_rand();
        val    = 16'($urandom);
        dp     = ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'h0;
        en     = ($urandom_range(0, 1) == 0) ? 4'hF : 4'($urandom);
        lz     = 1'($urandom);
        bright = 4'($urandom);
        // bias toward leading zeros so blanking is exercised
        if ($urandom_range(0, 2) == 0) val = val & 16'h00FF;
    endtask

    // phase p of the frame is the next edge's position; bounded search
    task automatic wait_phase(input int p);
        for (int k = 0; k < 4 * FRAME && (m_s % FRAME) != p; k++) @(negedge clk);
    endtask

    initial begin
        rst_n = 1'b0;
        drive_rand();
        cycles(3);

        // plain scan of 1234, full brightness
        rst_n = 1'b1; val = 16'h1234; en = 4'hF; bright = 4'd15; lz = 1'b0; dp = 4'h0;
        cycles(20);

        // change while digit 1 is shown: must only appear from next frame
        wait_phase(5);
        val = 16'hABCD;
        cycles(40);

        // leading zeros, then a decimal point protecting digit 2
        val = 16'h0005; lz = 1'b1; dp = 4'h0;
        cycles(40);
        dp = 4'b0100;
        cycles(40);

        // reduced brightness and a masked digit
        val = 16'h8421; lz = 1'b0; dp = 4'h0; bright = 4'd3; en = 4'b1011;
        cycles(48);

        // one-clock reset during digit 2, new value captured on release
        bright = 4'd15; en = 4'hF;
        wait_phase(9);
        rst_n = 1'b0; val = 16'h5A5A;
        cycles(1);
        rst_n = 1'b1;
        cycles(40);

        // randomized traffic with occasional resets
        for (int k = 0; k < 1200; k++) begin
            if ($urandom_range(0, 9) == 0) drive_rand();
            rst_n = ($urandom_range(0, 249) == 0) ? 1'b0 : 1'b1;
            @(negedge clk);
        end
        rst_n = 1'b1;
        cycles(2);

        end_chk = 1'b1;
        @(negedge clk);
        #1;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/seven_segment_mux_ctrl.md
SEVEN_SEGMENT_MUX_CTRL -- requirements
Module: seven_segment_mux_ctrl

Interface
REQ-001 Parameter NUM_DIGITS, default 8, number of multiplexed digits; legal range 1..16.
REQ-002 Parameter COUNT_TO, default 100_000, digit dwell = COUNT_TO+1 clocks; legal range >= 1.
REQ-003 clk_in  input  1  single clock; all logic on its rising edge.
REQ-004 rst_n_in  input  1  synchronous, active-low reset.
REQ-005 val_in  input  4*NUM_DIGITS  hex nibbles; digit i = val_in[4i+3:4i].
REQ-006 dp_in  input  NUM_DIGITS  decimal-point request per digit, active-high.
REQ-007 en_in  input  NUM_DIGITS  per-digit enable mask; 0 = digit always dark.
REQ-008 lz_en_in  input  1  leading-zero suppression enable.
REQ-009 bright_in  input  4  brightness level, 0 = dimmest, 15 = full.
REQ-010 cat_out  output  7  segment cathodes, active-low, segment order as the existing hex-to-7-seg decoder.
REQ-011 dp_out  output  1  decimal-point cathode, active-low.
REQ-012 an_out  output  NUM_DIGITS  digit anodes, active-low, at most one low at a time.
REQ-013 frame_done_out  output  1  one-cycle pulse per completed frame.

Function
REQ-014 Dwell counter cnt SHALL count 0..COUNT_TO and wrap to 0; on wrap the digit index idx SHALL advance by 1, wrapping from NUM_DIGITS-1 to 0.
REQ-015 Frame start = cycle with cnt==0 and idx==0; on that edge val_in, dp_in, en_in, lz_en_in, bright_in SHALL be captured into shadow registers; the display SHALL use only shadow values (no tearing mid-frame).
REQ-016 A free-running 4-bit pwm counter SHALL increment every clock, wrapping 15->0.
REQ-017 Digit idx is lit iff cnt!=0 (one-cycle ghosting guard), shadow en[idx]==1, digit not leading-zero blanked, and pwm <= shadow bright.
REQ-018 Leading-zero blank: digit i (i>0) blanked iff shadow lz_en==1 and all nibbles i..NUM_DIGITS-1 are 0 and all dp bits i..NUM_DIGITS-1 are 0; digit 0 never leading-zero blanked.
REQ-019 When lit: an_out bit idx low, others high; cat_out = inverted hex decode of shadow nibble idx (0-F); dp_out = ~shadow dp[idx]. When dark: an_out all 1, cat_out 7'h7F, dp_out 1.
REQ-020 cat_out, dp_out, an_out SHALL be registered: they reflect the decode of idx/cnt/pwm/shadow state of the previous cycle (latency 1 clock).
REQ-021 frame_done_out SHALL be high exactly one cycle, the cycle after cnt==COUNT_TO with idx==NUM_DIGITS-1.
REQ-022 Input changes between frame starts SHALL have no effect on outputs until the next frame start.
REQ-023 NUM_DIGITS==1: idx stays 0, every dwell period is a frame; frame_done_out pulses every COUNT_TO+1 clocks.

Reset
REQ-024 While rst_n_in==0 at a rising edge: cnt=0, idx=0, pwm=0, shadows=0, an_out all 1, cat_out 7'h7F, dp_out 1, frame_done_out 0.
REQ-025 Reset asserted mid-frame SHALL force the REQ-024 state on the next edge; first cycle after release is a frame start (shadow capture).
REQ-026 No output SHALL depend on any register not cleared by reset.

Verification (NUM_DIGITS=4, COUNT_TO=3 unless stated)
REQ-027 Reset: hold rst_n_in=0 3 clocks with arbitrary inputs -> an_out=4'b1111, cat_out=7'h7F, dp_out=1, frame_done_out=0 throughout.
REQ-028 Scan: val_in=16'h1234, en_in=4'hF, bright_in=15, lz_en_in=0 -> per 4-clock dwell, 1 dark clock then 3 clocks of an_out=1110/1101/1011/0111 with cat_out=~decode(4/3/2/1); frame_done_out pulses every 16 clocks.
REQ-029 Tear-free: change val_in 16'h1234 -> 16'hABCD while idx==1 -> digits 2,3 still show 2,1 this frame; A-D appear only from next frame start.
REQ-030 Leading zeros: val_in=16'h0005, lz_en_in=1, dp_in=0 -> only an_out=1110 ever low; then dp_in=4'b0100 -> digits 0,1,2 lit (digit 2 with dp_out=0), digit 3 never lit.
REQ-031 Brightness: COUNT_TO=63, bright_in=3, reset released with cnt/pwm aligned -> each digit lit exactly 15 clocks per 64-clock dwell (cnt mod 16 in 0..3, cnt!=0); en_in=4'b1011 -> an_out bit 2 never low.
REQ-032 Mid-frame reset: assert rst_n_in=0 one clock during digit 2 -> next cycle all dark, after release scan restarts at digit 0 with freshly captured val_in, frame_done_out first pulses 16 clocks after release.
